// File: rtl/cla_seq_mult_ctrl.sv
// Iterative unsigned shift-add multiplier: one WIDTH+1-bit add per cycle through a
// shared 32-bit carry-lookahead adder, with valid/ready handshakes on both sides.

module cla_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        gg,
  output logic        pp
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  bg;
  logic [7:0]  bp;

  assign g = a & b;
  assign p = a ^ b;

  // Eight 4-bit blocks: block generate/propagate feed a block-level carry chain.
  always_comb begin
    logic g_acc;
    c = '0;
    bg = '0;
    bp = '0;
    g_acc = 1'b0;
    c[0] = cin;
    for (int k = 0; k < 8; k++) begin
      bg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      bp[k] = &p[4*k +: 4];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
      if (k < 7) begin
        c[4*k+4] = bg[k] | (bp[k] & c[4*k]);
      end
      g_acc = bg[k] | (bp[k] & g_acc);
    end
    gg = g_acc;
    pp = &bp;
  end

  assign s = p ^ c;

endmodule

module cla_seq_mult_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     addend;
  logic [31:0]          add_a;
  logic [31:0]          add_b;
  logic [31:0]          add_s;
  logic                 add_gg;
  logic                 add_pp;
  logic [WIDTH:0]       sum;
  logic                 unused_cla;

  assign addend = acc_lo_q[0] ? mcand_q : '0;
  assign add_a  = {{(32-WIDTH){1'b0}}, acc_hi_q};
  assign add_b  = {{(32-WIDTH){1'b0}}, addend};

  cla_32 u_cla (
    .a   (add_a),
    .b   (add_b),
    .cin (1'b0),
    .s   (add_s),
    .gg  (add_gg),
    .pp  (add_pp)
  );

  // Bit WIDTH of the sum is the carry out of the partial-product add.
  assign sum        = add_s[WIDTH:0];
  assign unused_cla = ^{add_s[31:WIDTH+1], add_gg, add_pp};

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    count_d   = count_q;
    product_d = product_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mcand_d  = a;
          acc_hi_d = '0;
          acc_lo_d = b;
          count_d  = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        busy     = 1'b1;
        acc_hi_d = sum[WIDTH:1];
        acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
        count_d  = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          product_d = {acc_hi_d, acc_lo_d};
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // Operand and accumulator registers are qualified by the FSM, so they need no reset.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    acc_hi_q <= acc_hi_d;
    acc_lo_q <= acc_lo_d;
  end

  assign product = product_q;

endmodule

// File: tb/tb_cla_seq_mult_ctrl.sv
// Self-checking bench for cla_seq_mult_ctrl: directed cases plus a randomized
// back-to-back stream compared against a plain a*b reference with a product queue.

module tb_cla_seq_mult_ctrl;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  int n_checks;
  int n_fail;
  int cycle;

  cla_seq_mult_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    longint unsigned px;
    px = longint'(x) * longint'(y);
    return px[2*WIDTH-1:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Accept one pair, measure edges to out_valid, optionally stall, then complete.
  task automatic do_txn(input string tag, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                        input int stall);
    int lat;
    logic [2*WIDTH-1:0] exp_p;
    exp_p = ref_mul(xa, xb);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a = xa;
    b = xb;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    lat = 0;
    while (lat < 100) begin
      out_ready = 1'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      if (out_valid) break;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(WIDTH));
    chk({tag, "_product"}, 64'(product), 64'(exp_p));
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_product"}, 64'(product), 64'(exp_p));
      chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [2*WIDTH-1:0] exp_q[$];
    int accepted;
    int completed;
    int last_accept;
    int budget;
    bit acc_hs;
    bit out_hs;

    n_checks = 0;
    n_fail = 0;
    cycle = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_product", 64'(product), 64'd0);

    do_txn("t1_3x5", 16'd3, 16'd5, 0);
    do_txn("t2_ones", 16'hFFFF, 16'hFFFF, 0);
    do_txn("t3_b0", 16'h1234, 16'h0000, 0);
    do_txn("t3_a0", 16'h0000, 16'hBEEF, 0);
    do_txn("t4_stall", 16'h00C3, 16'h0A51, 10);

    // Reset in the middle of a run discards the transaction.
    @(negedge clk);
    in_valid = 1'b1;
    a = 16'hAAAA;
    b = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_product", 64'(product), 64'd0);
    begin
      bit seen;
      seen = 1'b0;
      repeat (WIDTH + 4) begin
        @(posedge clk);
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      chk("t5_no_out_valid", 64'(seen), 64'd0);
    end
    do_txn("t5_after", 16'hAAAA, 16'h5555, 0);

    // Randomized back-to-back stream.
    accepted = 0;
    completed = 0;
    last_accept = -1000;
    budget = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    while (completed < 200 && budget < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      acc_hs = in_valid && in_ready;
      out_hs = out_valid && out_ready;
      if (out_hs) begin
        if (exp_q.size() == 0) begin
          chk("t6_spurious_out", 64'(out_valid), 64'd0);
        end else begin
          chk("t6_product", 64'(product), 64'(exp_q.pop_front()));
        end
        completed++;
      end
      if (acc_hs) begin
        if (accepted > 0) begin
          chk("t6_spacing_ok", 64'(cycle - last_accept >= WIDTH + 2), 64'd1);
        end
        exp_q.push_back(ref_mul(a, b));
        last_accept = cycle;
        accepted++;
      end
      @(posedge clk);
      budget++;
      @(negedge clk);
      if (acc_hs) begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        in_valid = (accepted < 200);
      end
    end
    chk("t6_completed", 64'(completed), 64'd200);
    in_valid = 1'b0;
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
